// File: rtl/mem_data_arbiter.sv
// Two-port req/ack arbiter and sequencer for a single-port 64x8 data memory.
// Build option MEMARB_FIXED_PRIO_EN: port A always wins contention instead of round-robin.
module mem_data_arbiter #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] wdata_a,
   output logic          ack_a,
   output logic [DW-1:0] rdata_a,
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          ack_b,
   output logic [DW-1:0] rdata_b,
   output logic          busy,
   output logic          mem_wr,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wrdata,
   input  logic [DW-1:0] mem_rddata
);

   // state  | meaning
   // IDLE   | waiting for a request, arbitration happens here
   // ACCESS | memory enables driven for the latched transaction
   // DONE   | ack pulse to the winner
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state;
   logic          win;          // 0 = A, 1 = B
   logic          last_grant;   // 0 = A, 1 = B
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          ack_a_q;
   logic          ack_b_q;
   logic          grant_any;
   logic          grant_b;

   always_comb begin
      grant_any = req_a | req_b;
`ifdef MEMARB_FIXED_PRIO_EN
      grant_b   = req_b & ~req_a;
`else
      grant_b   = req_b & (~req_a | ~last_grant);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         win        <= 1'b0;
         last_grant <= 1'b1;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         rdata_a    <= '0;
         rdata_b    <= '0;
      end else begin
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  win        <= grant_b;
                  last_grant <= grant_b;
                  lat_we     <= grant_b ? we_b    : we_a;
                  lat_addr   <= grant_b ? addr_b  : addr_a;
                  lat_wdata  <= grant_b ? wdata_b : wdata_a;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (!lat_we) begin
                  if (win) rdata_b <= mem_rddata;
                  else     rdata_a <= mem_rddata;
               end
               ack_a_q <= ~win;
               ack_b_q <= win;
               state   <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Gated by rst so a reset in ACCESS/DONE blocks the write and the ack in that same cycle.
   assign ack_a      = ack_a_q & ~rst;
   assign ack_b      = ack_b_q & ~rst;
   assign mem_wr     = (state == ACCESS) &  lat_we & ~rst;
   assign mem_rd     = (state == ACCESS) & ~lat_we & ~rst;
   assign mem_addr   = lat_addr;
   assign mem_wrdata = lat_wdata;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: memory model, transaction-level reference model, directed tests.
module tb_mem_data_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, we_a, req_b, we_b;
   logic [5:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       ack_a, ack_b, busy, mem_wr, mem_rd;
   logic [7:0] rdata_a, rdata_b, mem_wrdata, mem_rddata;
   logic [5:0] mem_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_on   = 0;

   mem_data_arbiter #(.AW(6), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_b(ack_b), .rdata_b(rdata_b),
      .busy(busy), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Physical memory seen by the DUT; initial contents are addr ^ 8'h5A.
   logic [7:0] bmem [64];
   initial for (int i = 0; i < 64; i++) bmem[i] <= 8'(i) ^ 8'h5A;
   always @(posedge clk) if (mem_wr) bmem[mem_addr] <= mem_wrdata;
   assign mem_rddata = bmem[mem_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a transaction takes 3 cycles (phase 0 idle, 1 memory access, 2 ack).
   logic [7:0] ref_mem [64];
   initial for (int i = 0; i < 64; i++) ref_mem[i] <= 8'(i) ^ 8'h5A;
   int         m_phase;
   bit         m_win, m_last, m_we;
   logic [5:0] m_addr;
   logic [7:0] m_wd, m_rd_a, m_rd_b;

   function automatic bit pick_b();
`ifdef MEMARB_FIXED_PRIO_EN
      return !req_a;
`else
      if (req_a && req_b) return (m_last == 1'b0);
      return req_b;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0; m_last <= 1'b1; m_rd_a <= 8'h00; m_rd_b <= 8'h00;
         m_addr <= 6'h00; m_wd <= 8'h00;
      end else if (m_phase == 0) begin
         if (req_a || req_b) begin
            m_win   <= pick_b();
            m_last  <= pick_b();
            m_we    <= pick_b() ? we_b : we_a;
            m_addr  <= pick_b() ? addr_b : addr_a;
            m_wd    <= pick_b() ? wdata_b : wdata_a;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         if (m_we) ref_mem[m_addr] <= m_wd;
         else if (m_win) m_rd_b <= ref_mem[m_addr];
         else m_rd_a <= ref_mem[m_addr];
         m_phase <= 2;
      end else begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) if (chk_on) begin
      chk("ack_a",      ack_a,      32'(m_phase == 2 && !m_win && !rst));
      chk("ack_b",      ack_b,      32'(m_phase == 2 &&  m_win && !rst));
      chk("busy",       busy,       32'(m_phase != 0));
      chk("mem_wr",     mem_wr,     32'(m_phase == 1 &&  m_we && !rst));
      chk("mem_rd",     mem_rd,     32'(m_phase == 1 && !m_we && !rst));
      chk("mem_addr",   mem_addr,   32'(m_addr));
      chk("mem_wrdata", mem_wrdata, 32'(m_wd));
      chk("rdata_a",    rdata_a,    32'(m_rd_a));
      chk("rdata_b",    rdata_b,    32'(m_rd_b));
   end

   task automatic idle_inputs();
      req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   // Runs one transaction; returns the read data at ack, the last memory access seen, and the ack cycle.
   task automatic do_txn(input bit pb, input bit we, input logic [5:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic [5:0] acc_a, output logic [7:0] acc_d,
                         output bit acc_w, output int ack_cyc);
      bit got = 0;
      rd = 0; acc_a = 0; acc_d = 0; acc_w = 0; ack_cyc = 0;
      if (pb) begin req_b = 1; we_b = we; addr_b = a; wdata_b = d; end
      else    begin req_a = 1; we_a = we; addr_a = a; wdata_a = d; end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_wr || mem_rd) begin acc_a = mem_addr; acc_d = mem_wrdata; acc_w = mem_wr; end
         if (pb ? ack_b : ack_a) begin
            got = 1; rd = pb ? rdata_b : rdata_a; ack_cyc = cyc;
            break;
         end
      end
      chk(pb ? "ack_b_timeout" : "ack_a_timeout", 32'(got), 1);
      @(posedge clk); #1;
      if (pb) req_b = 0; else req_a = 0;
   endtask

   logic [7:0] rd, rd2, acc_d;
   logic [5:0] acc_a;
   bit         acc_w, acc_w2;
   logic [5:0] acc_a2;
   logic [7:0] acc_d2;
   int         c1, c2;
   int         seq[$];
   int         seq_cyc[$];
   logic [5:0] b_addrs[$];
   int         b_cyc[$];
   logic [7:0] b_rd[$];

   initial begin
      // 1: reset with random inputs
      rst = 1;
      req_a = 1'($urandom); we_a = 1'($urandom); addr_a = 6'($urandom); wdata_a = 8'($urandom);
      req_b = 1'($urandom); we_b = 1'($urandom); addr_b = 6'($urandom); wdata_b = 8'($urandom);
      @(posedge clk); #1 chk_on = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack_a", ack_a, 0);   chk("rst_ack_b", ack_b, 0);
      chk("rst_busy", busy, 0);     chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_rd", mem_rd, 0); chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata_a", rdata_a, 0); chk("rst_rdata_b", rdata_b, 0);
      @(posedge clk); #1 rst = 0; idle_inputs();

      // 2: write then read on A
      do_txn(0, 1, 6'h05, 8'hA5, rd, acc_a, acc_d, acc_w, c1);
      chk("t2_wr_en", acc_w, 1); chk("t2_wr_addr", acc_a, 6'h05); chk("t2_wr_data", acc_d, 8'hA5);
      do_txn(0, 0, 6'h05, 8'h00, rd, acc_a, acc_d, acc_w, c1);
      chk("t2_rd_en", acc_w, 0); chk("t2_rdata_a", rd, 8'hA5); chk("t2_rdata_b_hold", rdata_b, 8'h00);

      // 3: contention right after reset, A reads old value then B writes
      do_reset();
      fork
         do_txn(0, 0, 6'h3F, 8'h00, rd,  acc_a,  acc_d,  acc_w,  c1);
         do_txn(1, 1, 6'h3F, 8'h3C, rd2, acc_a2, acc_d2, acc_w2, c2);
      join
      chk("t3_a_old", rd, 8'h65); chk("t3_b_write", acc_w2, 1); chk("t3_b_wdata", acc_d2, 8'h3C);
      chk("t3_spacing", 32'(c2 - c1), 3);
      do_txn(0, 0, 6'h3F, 8'h00, rd, acc_a, acc_d, acc_w, c1);
      chk("t3_reread", rd, 8'h3C);

      // 4: sustained contention for 12 cycles
      do_reset();
      req_a = 1; we_a = 0; addr_a = 6'h20;
      req_b = 1; we_b = 0; addr_b = 6'h21;
      repeat (12) begin
         @(negedge clk);
         if (ack_a) begin seq.push_back(0); seq_cyc.push_back(cyc); end
         if (ack_b) begin seq.push_back(1); seq_cyc.push_back(cyc); end
      end
      @(posedge clk); #1 idle_inputs();
      chk("t4_ack_count", 32'(seq.size()), 4);
      for (int i = 0; i < seq.size() && i < 4; i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
         chk("t4_order", 32'(seq[i]), 0);
`else
         chk("t4_order", 32'(seq[i]), 32'(i % 2));
`endif
         if (i > 0) chk("t4_spacing", 32'(seq_cyc[i] - seq_cyc[i-1]), 3);
      end

      // 5: reset during ACCESS drops the write
      repeat (2) @(posedge clk);
      #1 req_a = 1; we_a = 1; addr_a = 6'h10; wdata_a = 8'hFF;
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("t5_no_wr", mem_wr, 0); chk("t5_no_ack", ack_a, 0);
      @(posedge clk); #1 rst = 0; idle_inputs();
      repeat (3) begin
         @(negedge clk);
         chk("t5_no_ack_after", ack_a, 0); chk("t5_idle", busy, 0);
      end
      @(posedge clk); #1;
      do_txn(0, 0, 6'h10, 8'h00, rd, acc_a, acc_d, acc_w, c1);
      chk("t5_prior_value", rd, 8'h4A);

      // 6: back-to-back reads on B, address changes after first ack
      req_b = 1; we_b = 0; addr_b = 6'h01;
      for (int i = 0; i < 30 && b_cyc.size() < 2; i++) begin
         @(negedge clk);
         if (mem_rd) b_addrs.push_back(mem_addr);
         if (ack_b) begin
            b_cyc.push_back(cyc); b_rd.push_back(rdata_b);
            addr_b = 6'h02;
         end
      end
      @(posedge clk); #1 idle_inputs();
      chk("t6_ack_count", 32'(b_cyc.size()), 2);
      chk("t6_access_count", 32'(b_addrs.size()), 2);
      if (b_cyc.size() == 2) begin
         chk("t6_spacing", 32'(b_cyc[1] - b_cyc[0]), 3);
         chk("t6_rd1", b_rd[0], 8'h5B); chk("t6_rd2", b_rd[1], 8'h58);
      end
      if (b_addrs.size() == 2) begin
         chk("t6_addr1", b_addrs[0], 6'h01); chk("t6_addr2", b_addrs[1], 6'h02);
      end

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end
endmodule
